// File: rtl/ex_alu_mc.sv
// Execute-stage ALU: single-cycle logic/shift/arith ops plus an iterative shift-add multiplier.
// Define EX_ALU_DIV_EN to add the iterative restoring divider (DIV/DIVU); otherwise they decode as unknown.
module ex_alu_mc #(
    parameter int WIDTH  = 32,
    parameter int ADDR_W = 5,
    parameter int OP_W   = 8
) (
    input  logic              clk,
    input  logic              rst,
    // valid/ready: an op transfers on a rising edge where in_valid_i && in_ready_o; while busy, upstream holds it.
    input  logic              in_valid_i,
    output logic              in_ready_o,
    input  logic              flush_i,
    input  logic [OP_W-1:0]   aluop_i,
    input  logic [WIDTH-1:0]  reg1_i,
    input  logic [WIDTH-1:0]  reg2_i,
    input  logic [ADDR_W-1:0] wd_i,
    input  logic              wreg_i,
    output logic              out_valid_o,
    output logic [ADDR_W-1:0] wd_o,
    output logic              wreg_o,
    output logic [WIDTH-1:0]  wdata_o,
    output logic [WIDTH-1:0]  hi_o,
    output logic              whilo_o,
    output logic              busy_o,
    output logic [1:0]        dbg_state
);

    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [OP_W-1:0] OP_AND   = OP_W'('h24);
    localparam logic [OP_W-1:0] OP_OR    = OP_W'('h25);
    localparam logic [OP_W-1:0] OP_XOR   = OP_W'('h26);
    localparam logic [OP_W-1:0] OP_NOR   = OP_W'('h27);
    localparam logic [OP_W-1:0] OP_ADD   = OP_W'('h20);
    localparam logic [OP_W-1:0] OP_SUB   = OP_W'('h22);
    localparam logic [OP_W-1:0] OP_SLT   = OP_W'('h2A);
    localparam logic [OP_W-1:0] OP_SLL   = OP_W'('h00);
    localparam logic [OP_W-1:0] OP_SRL   = OP_W'('h02);
    localparam logic [OP_W-1:0] OP_SRA   = OP_W'('h03);
    localparam logic [OP_W-1:0] OP_MULT  = OP_W'('h18);
    localparam logic [OP_W-1:0] OP_MULTU = OP_W'('h19);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
`ifdef EX_ALU_DIV_EN
        S_DIV  = 2'd2,
`endif
        S_MUL  = 2'd1
    } state_t;

    state_t             state, state_nxt;
    logic [CNT_W-1:0]   cnt;
    logic [WIDTH-1:0]   acc_hi, acc_lo, opnd;
    logic               neg_q;
    logic [ADDR_W-1:0]  wd_q;

    logic               accept, is_mult, sgn_op, a_neg, b_neg;
    logic [WIDTH-1:0]   a_mag, b_mag;
    logic [CNT_W-1:0]   shamt;
    logic [WIDTH-1:0]   alu_res;
    logic               alu_wreg;
    logic [WIDTH:0]     mul_sum;
    logic [2*WIDTH-1:0] mul_prod, mul_final;

    assign accept     = in_valid_i & in_ready_o;
    assign in_ready_o = rst & (state == S_IDLE);
    assign busy_o     = (state != S_IDLE);
    assign dbg_state  = state;
    assign is_mult    = (aluop_i == OP_MULT) || (aluop_i == OP_MULTU);
    assign shamt      = reg1_i[CNT_W-1:0];

`ifdef EX_ALU_DIV_EN
    localparam logic [OP_W-1:0] OP_DIV  = OP_W'('h1A);
    localparam logic [OP_W-1:0] OP_DIVU = OP_W'('h1B);
    logic             neg_r, is_div, div_ok;
    logic [WIDTH:0]   div_trial;
    logic [WIDTH-1:0] div_hi_nxt, div_lo_nxt;

    assign is_div = (aluop_i == OP_DIV) || (aluop_i == OP_DIVU);
    assign sgn_op = (aluop_i == OP_MULT) || (aluop_i == OP_DIV);
    // Restoring step: shift the next dividend bit into the partial remainder and try the subtract.
    assign div_trial  = {acc_hi, acc_lo[WIDTH-1]} - {1'b0, opnd};
    assign div_ok     = ~div_trial[WIDTH];
    assign div_hi_nxt = div_ok ? div_trial[WIDTH-1:0] : {acc_hi[WIDTH-2:0], acc_lo[WIDTH-1]};
    assign div_lo_nxt = {acc_lo[WIDTH-2:0], div_ok};
`else
    assign sgn_op = (aluop_i == OP_MULT);
`endif

    // Signed ops iterate on magnitudes; the sign is restored on the final step.
    assign a_neg = sgn_op & reg1_i[WIDTH-1];
    assign b_neg = sgn_op & reg2_i[WIDTH-1];
    assign a_mag = a_neg ? (~reg1_i + 1'b1) : reg1_i;
    assign b_mag = b_neg ? (~reg2_i + 1'b1) : reg2_i;

    // Shift-add step: {acc_hi,acc_lo} holds partial product over the not-yet-consumed multiplier bits.
    assign mul_sum   = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opnd} : '0);
    assign mul_prod  = {mul_sum, acc_lo[WIDTH-1:1]};
    assign mul_final = neg_q ? (~mul_prod + 1'b1) : mul_prod;

    always_comb begin
        alu_res  = '0;
        alu_wreg = wreg_i;
        case (aluop_i)
            OP_AND:  alu_res = reg1_i & reg2_i;
            OP_OR:   alu_res = reg1_i | reg2_i;
            OP_XOR:  alu_res = reg1_i ^ reg2_i;
            OP_NOR:  alu_res = ~(reg1_i | reg2_i);
            OP_ADD:  alu_res = reg1_i + reg2_i;
            OP_SUB:  alu_res = reg1_i - reg2_i;
            OP_SLT:  alu_res = {{(WIDTH-1){1'b0}}, ($signed(reg1_i) < $signed(reg2_i))};
            OP_SLL:  alu_res = reg2_i << shamt;
            OP_SRL:  alu_res = reg2_i >> shamt;
            OP_SRA:  alu_res = $signed(reg2_i) >>> shamt;
            default: alu_wreg = 1'b0;
        endcase
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (accept && is_mult) state_nxt = S_MUL;
`ifdef EX_ALU_DIV_EN
                else if (accept && is_div && (reg2_i != '0)) state_nxt = S_DIV;
`endif
            end
            default: if (cnt == '0) state_nxt = S_IDLE;
        endcase
        if (flush_i) state_nxt = S_IDLE;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= S_IDLE;
            cnt <= '0;
            acc_hi <= '0;
            acc_lo <= '0;
            opnd <= '0;
            neg_q <= 1'b0;
`ifdef EX_ALU_DIV_EN
            neg_r <= 1'b0;
`endif
            wd_q <= '0;
            out_valid_o <= 1'b0;
            wd_o <= '0;
            wreg_o <= 1'b0;
            wdata_o <= '0;
            hi_o <= '0;
            whilo_o <= 1'b0;
        end else begin
            state <= state_nxt;
            out_valid_o <= 1'b0;
            if (flush_i) begin
                cnt <= '0;
            end else if (state == S_IDLE) begin
                if (accept && is_mult) begin
                    acc_hi <= '0;
                    acc_lo <= b_mag;
                    opnd <= a_mag;
                    neg_q <= a_neg ^ b_neg;
                    cnt <= CNT_W'(WIDTH-1);
                    wd_q <= wd_i;
`ifdef EX_ALU_DIV_EN
                end else if (accept && is_div && (reg2_i != '0)) begin
                    acc_hi <= '0;
                    acc_lo <= a_mag;
                    opnd <= b_mag;
                    neg_q <= a_neg ^ b_neg;
                    neg_r <= a_neg;
                    cnt <= CNT_W'(WIDTH-1);
                    wd_q <= wd_i;
                end else if (accept && is_div) begin
                    out_valid_o <= 1'b1;
                    wd_o <= wd_i;
                    wreg_o <= 1'b0;
                    whilo_o <= 1'b1;
                    wdata_o <= '1;
                    hi_o <= reg1_i;
`endif
                end else if (accept) begin
                    out_valid_o <= 1'b1;
                    wd_o <= wd_i;
                    wreg_o <= alu_wreg;
                    wdata_o <= alu_res;
                    whilo_o <= 1'b0;
                end
            end else if (state == S_MUL) begin
                {acc_hi, acc_lo} <= mul_prod;
                if (cnt != '0) begin
                    cnt <= cnt - 1'b1;
                end else begin
                    out_valid_o <= 1'b1;
                    wd_o <= wd_q;
                    wreg_o <= 1'b0;
                    whilo_o <= 1'b1;
                    {hi_o, wdata_o} <= mul_final;
                end
`ifdef EX_ALU_DIV_EN
            end else begin
                acc_hi <= div_hi_nxt;
                acc_lo <= div_lo_nxt;
                if (cnt != '0) begin
                    cnt <= cnt - 1'b1;
                end else begin
                    out_valid_o <= 1'b1;
                    wd_o <= wd_q;
                    wreg_o <= 1'b0;
                    whilo_o <= 1'b1;
                    wdata_o <= neg_q ? (~div_lo_nxt + 1'b1) : div_lo_nxt;
                    hi_o <= neg_r ? (~div_hi_nxt + 1'b1) : div_hi_nxt;
                end
`endif
            end
        end
    end

endmodule

// File: tb/tb_ex_alu_mc.sv
// Directed bench for ex_alu_mc (WIDTH=32): single-cycle ops, MULT/MULTU, flush, async reset, DIV/DIVU.
module tb_ex_alu_mc;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic        flush = 1'b0;
    logic [7:0]  aluop = '0;
    logic [31:0] reg1 = '0;
    logic [31:0] reg2 = '0;
    logic [4:0]  wd_in = '0;
    logic        wreg_in = 1'b0;
    logic        out_valid;
    logic [4:0]  wd;
    logic        wreg;
    logic [31:0] wdata;
    logic [31:0] hi;
    logic        whilo;
    logic        busy;
    logic [1:0]  dbg_state;

    int n_checks = 0;
    int n_fail = 0;
    logic [31:0] exp_q[$];

    ex_alu_mc #(.WIDTH(32), .ADDR_W(5), .OP_W(8)) dut (
        .clk(clk), .rst(rst), .in_valid_i(in_valid), .in_ready_o(in_ready), .flush_i(flush),
        .aluop_i(aluop), .reg1_i(reg1), .reg2_i(reg2), .wd_i(wd_in), .wreg_i(wreg_in),
        .out_valid_o(out_valid), .wd_o(wd), .wreg_o(wreg), .wdata_o(wdata), .hi_o(hi),
        .whilo_o(whilo), .busy_o(busy), .dbg_state(dbg_state)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic issue(input logic [7:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] d, input logic wr);
        @(negedge clk);
        aluop = op; reg1 = a; reg2 = b; wd_in = d; wreg_in = wr; in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    task automatic wait_result(input int budget, output int lat, output int busy_cnt);
        lat = 0;
        busy_cnt = 0;
        for (int i = 1; i <= budget; i++) begin
            @(negedge clk);
            if (out_valid) begin
                lat = i;
                break;
            end
            if (busy) busy_cnt++;
        end
    endtask

    // Issues an op, expects wdata/hi/flags after a fixed latency, then a single-cycle pulse.
    task automatic run_op(input string tag, input logic [7:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [4:0] d, input logic [31:0] exp_lo,
                          input logic [31:0] exp_hi, input logic chk_hi, input logic exp_wreg,
                          input logic exp_whilo, input int exp_lat);
        int lat, bc;
        issue(op, a, b, d, 1'b1);
        exp_q.push_back(exp_lo);
        wait_result(exp_lat + 5, lat, bc);
        check({tag, "_lat"}, 64'(lat), 64'(exp_lat));
        check({tag, "_wdata"}, 64'(wdata), 64'(exp_q.pop_front()));
        if (chk_hi) check({tag, "_hi"}, 64'(hi), 64'(exp_hi));
        check({tag, "_wreg"}, 64'(wreg), 64'(exp_wreg));
        check({tag, "_whilo"}, 64'(whilo), 64'(exp_whilo));
        check({tag, "_wd"}, 64'(wd), 64'(d));
        check({tag, "_busycyc"}, 64'(bc), 64'(exp_lat - 1));
        @(negedge clk);
        check({tag, "_pulse"}, 64'(out_valid), 64'(0));
    endtask

    logic [7:0]  t_op  [0:11] = '{8'h25, 8'h24, 8'h26, 8'h27, 8'h20, 8'h22,
                                  8'h2A, 8'h2A, 8'h00, 8'h02, 8'h03, 8'h3F};
    logic [31:0] t_a   [0:11] = '{32'h0000_F0F0, 32'hFF00_FF00, 32'hAAAA_5555, 32'h0000_FFFF,
                                  32'hFFFF_FFFF, 32'h0000_0005, 32'hFFFF_FFFF, 32'h0000_0001,
                                  32'h0000_0024, 32'h0000_001F, 32'h0000_0004, 32'h1234_5678};
    logic [31:0] t_b   [0:11] = '{32'h0F0F_0000, 32'h0FF0_0FF0, 32'hFFFF_0000, 32'h00FF_0000,
                                  32'h0000_0001, 32'h0000_0007, 32'h0000_0001, 32'hFFFF_FFFF,
                                  32'h0000_000F, 32'h8000_0000, 32'h8000_0000, 32'h0000_0001};
    logic [31:0] t_exp [0:11] = '{32'h0F0F_F0F0, 32'h0F00_0F00, 32'h5555_5555, 32'hFF00_0000,
                                  32'h0000_0000, 32'hFFFF_FFFE, 32'h0000_0001, 32'h0000_0000,
                                  32'h0000_00F0, 32'h0000_0001, 32'hF800_0000, 32'h0000_0000};

    initial begin
        int lat, bc, spurious;
        #12;
        check("rst_valid", 64'(out_valid), 64'(0));
        check("rst_busy", 64'(busy), 64'(0));
        check("rst_ready", 64'(in_ready), 64'(0));
        check("rst_data", {hi, wdata}, 64'(0));
        check("rst_flags", {wd, wreg, whilo}, 64'(0));
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("ready_idle", 64'(in_ready), 64'(1));
        check("state_idle", 64'(dbg_state), 64'(0));

        for (int i = 0; i < 12; i++)
            run_op($sformatf("op%02h_%0d", t_op[i], i), t_op[i], t_a[i], t_b[i], 5'(i + 5),
                   t_exp[i], 32'h0, 1'b0, (t_op[i] != 8'h3F), 1'b0, 1);

        run_op("mult_neg", 8'h18, 32'hFFFF_FFFD, 32'h0000_0007, 5'd3,
               32'hFFFF_FFEB, 32'hFFFF_FFFF, 1'b1, 1'b0, 1'b1, 33);
        run_op("mult_nn", 8'h18, 32'hFFFF_FFFB, 32'hFFFF_FFFA, 5'd4,
               32'h0000_001E, 32'h0000_0000, 1'b1, 1'b0, 1'b1, 33);
        run_op("multu_max", 8'h19, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd6,
               32'h0000_0001, 32'hFFFF_FFFE, 1'b1, 1'b0, 1'b1, 33);

        // MULTU killed by a flush in its 10th cycle; an ADD follows immediately.
        issue(8'h19, 32'h1234_5678, 32'h9ABC_DEF0, 5'd7, 1'b1);
        spurious = 0;
        for (int i = 0; i < 9; i++) begin
            @(negedge clk);
            if (out_valid) spurious++;
        end
        check("flush_busy_before", 64'(busy), 64'(1));
        flush = 1'b1;
        @(posedge clk);
        #1 flush = 1'b0;
        @(negedge clk);
        if (out_valid) spurious++;
        check("flush_idle", {62'(0), busy, in_ready}, 64'(1));
        run_op("add_after_flush", 8'h20, 32'h0000_0010, 32'h0000_0022, 5'd8,
               32'h0000_0032, 32'h0, 1'b0, 1'b1, 1'b0, 1);
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (out_valid) spurious++;
        end
        check("flush_no_result", 64'(spurious), 64'(0));

        // Accept and flush in the same cycle: the op is discarded.
        @(negedge clk);
        aluop = 8'h25; reg1 = 32'h1; reg2 = 32'h2; wd_in = 5'd9; wreg_in = 1'b1;
        in_valid = 1'b1; flush = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0; flush = 1'b0;
        @(negedge clk);
        check("flush_same_cycle", {62'(0), out_valid, busy}, 64'(0));

`ifdef EX_ALU_DIV_EN
        run_op("div_neg", 8'h1A, 32'hFFFF_FFF9, 32'h0000_0002, 5'd10,
               32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b1, 1'b0, 1'b1, 33);
        run_op("divu_big", 8'h1B, 32'hFFFF_FFFF, 32'h0000_0010, 5'd11,
               32'h0FFF_FFFF, 32'h0000_000F, 1'b1, 1'b0, 1'b1, 33);
        run_op("divu_zero", 8'h1B, 32'h0000_0009, 32'h0000_0000, 5'd12,
               32'hFFFF_FFFF, 32'h0000_0009, 1'b1, 1'b0, 1'b1, 1);
`else
        run_op("div_off", 8'h1A, 32'hFFFF_FFF9, 32'h0000_0002, 5'd10,
               32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1);
        run_op("divu_off", 8'h1B, 32'h0000_0009, 32'h0000_0000, 5'd12,
               32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1);
`endif

        // Async reset in the middle of a MULT.
        issue(8'h18, 32'hFFFF_FFFD, 32'h0000_0007, 5'd13, 1'b1);
        repeat (5) @(negedge clk);
        #2 rst = 1'b0;
        #1;
        check("arst_valid", 64'(out_valid), 64'(0));
        check("arst_busy", 64'(busy), 64'(0));
        check("arst_data", {hi, wdata}, 64'(0));
        check("arst_flags", {wd, wreg, whilo}, 64'(0));
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("arst_ready", 64'(in_ready), 64'(1));
        wait_result(40, lat, bc);
        check("arst_no_result", 64'(lat), 64'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
